// File: rtl/rv_pkg.sv
// Shared integer-pipeline types: register value width, register index width and write-back entry.
package rv_pkg;

    localparam int XLEN   = 64;
    localparam int REG_AW = 5;
    localparam int NREGS  = 1 << REG_AW;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wb_ctrl_if.sv
// Write-back controller bus: ALU/LSU result ports, issue-stage scoreboard lookups and regfile write port.
// Forwarding outputs exist only when WB_BYPASS_EN is defined.
interface wb_ctrl_if;
    import rv_pkg::*;

    logic              alu_valid;
    logic [REG_AW-1:0] alu_rd;
    logic [XLEN-1:0]   alu_data;
    logic              alu_stall;

    logic              lsu_valid;
    logic              lsu_ready;
    logic [REG_AW-1:0] lsu_rd;
    logic [XLEN-1:0]   lsu_data;

    logic              iss_valid;
    logic [REG_AW-1:0] iss_rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              rs1_busy;
    logic              rs2_busy;

    logic              rf_wen;
    logic [REG_AW-1:0] rf_rd;
    logic [XLEN-1:0]   rf_wdata;

`ifdef WB_BYPASS_EN
    logic              rs1_fwd;
    logic              rs2_fwd;
    logic [XLEN-1:0]   rs1_fwd_data;
    logic [XLEN-1:0]   rs2_fwd_data;
`endif

    modport master (
        output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        output iss_valid, iss_rd, rs1, rs2,
        input  alu_stall, lsu_ready, rs1_busy, rs2_busy, rf_wen, rf_rd, rf_wdata
`ifdef WB_BYPASS_EN
        , input rs1_fwd, rs2_fwd, rs1_fwd_data, rs2_fwd_data
`endif
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        input  iss_valid, iss_rd, rs1, rs2,
        output alu_stall, lsu_ready, rs1_busy, rs2_busy, rf_wen, rf_rd, rf_wdata
`ifdef WB_BYPASS_EN
        , output rs1_fwd, rs2_fwd, rs1_fwd_data, rs2_fwd_data
`endif
    );

endinterface

// File: rtl/wb_ctrl_fifo.sv
// wb_fifo: small power-of-two queue of write-back entries for long-latency results.
module wb_fifo
    import rv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  wb_entry_t push_data,
    input  logic      pop,
    output wb_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    wb_entry_t       mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;

    // The extra pointer bit tells a full queue apart from an empty one.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/wb_ctrl.sv
// Write-back controller: arbitrates ALU and queued long-latency results onto the regfile write port
// and tracks busy registers. Define WB_BYPASS_EN to add forwarding from the output register.
module wb_ctrl
    import rv_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input logic     clk,
    input logic     rst,
    wb_ctrl_if.slave bus
);

    logic              q_full;
    logic              q_empty;
    logic              q_push;
    logic              q_pop;
    wb_entry_t         q_head;
    wb_entry_t         lsu_entry;
    wb_entry_t         alu_entry;
    wb_entry_t         sel;
    logic              sel_valid;
    logic              sel_from_q;

    logic              rf_wen;
    logic              rf_from_q;
    logic [REG_AW-1:0] rf_rd;
    logic [XLEN-1:0]   rf_wdata;

    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  busy_next;

    assign lsu_entry     = '{rd: bus.lsu_rd, data: bus.lsu_data};
    assign alu_entry     = '{rd: bus.alu_rd, data: bus.alu_data};
    assign bus.lsu_ready = !q_full && !rst;
    assign bus.alu_stall = q_full;
    assign q_push        = bus.lsu_valid && bus.lsu_ready;
    assign q_pop         = !bus.alu_valid && !q_empty;

    wb_fifo #(.DEPTH(QDEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (q_push),
        .push_data (lsu_entry),
        .pop       (q_pop),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty)
    );

    // ALU always wins the write port; the queue only drains in ALU-idle cycles.
    always_comb begin
        sel        = alu_entry;
        sel_valid  = 1'b1;
        sel_from_q = 1'b0;
        if (!bus.alu_valid) begin
            sel        = q_head;
            sel_valid  = !q_empty;
            sel_from_q = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wen    <= 1'b0;
            rf_from_q <= 1'b0;
            rf_rd     <= '0;
            rf_wdata  <= '0;
        end else begin
            rf_wen    <= sel_valid && (sel.rd != '0);
            rf_from_q <= sel_valid && sel_from_q;
            if (sel_valid) begin
                rf_rd    <= sel.rd;
                rf_wdata <= sel.data;
            end
        end
    end

    // A new issue to the same register outranks the clear from the write leaving this cycle.
    always_comb begin
        busy_next = busy;
        if (rf_wen && rf_from_q) begin
            busy_next[rf_rd] = 1'b0;
        end
        if (bus.iss_valid) begin
            busy_next[bus.iss_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign bus.rs1_busy = busy[bus.rs1];
    assign bus.rs2_busy = busy[bus.rs2];
    assign bus.rf_wen   = rf_wen;
    assign bus.rf_rd    = rf_rd;
    assign bus.rf_wdata = rf_wdata;

`ifdef WB_BYPASS_EN
    assign bus.rs1_fwd      = rf_wen && (rf_rd == bus.rs1) && (bus.rs1 != '0);
    assign bus.rs2_fwd      = rf_wen && (rf_rd == bus.rs2) && (bus.rs2 != '0);
    assign bus.rs1_fwd_data = rf_wdata;
    assign bus.rs2_fwd_data = rf_wdata;
`endif

endmodule
